// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding, byte width and index sizing.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START0 = 3'd1,
        WAIT0  = 3'd2,
        START1 = 3'd3,
        WAIT1  = 3'd4,
        ACK    = 3'd5
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_valid
);

    always_comb begin
        logic [N_REQ-1:0] rot;
        logic [IW:0]      sum;
        // rot[k] is the request k positions after ptr
        rot         = N_REQ'({req, req} >> ptr);
        sum         = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N_REQ)) begin
                    sum = sum - (IW+1)'(N_REQ);
                end
                grant_idx   = sum[IW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART byte transmitter; each grant sends a response byte then a data byte.
// Optional per-byte tx_done watchdog enabled by defining UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [BYTE_W*N_REQ-1:0]   resp_in,
    input  logic [BYTE_W*N_REQ-1:0]   dado_in,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [2:0]                dbg_state
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t        state, state_nx;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [BYTE_W-1:0] resp_q;
    logic [BYTE_W-1:0] dado_q;
    logic              done_ok;
    logic              timed_out;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req         (req),
        .ptr         (rr_ptr),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // A tx_done coinciding with our own tx_start cannot belong to the byte just launched.
    assign done_ok = tx_done && !tx_start;

`ifdef UART_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer;
    logic          to_flag;

    assign timed_out = ((state == WAIT0) || (state == WAIT1)) && !done_ok &&
                       (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            to_flag <= 1'b0;
        end else begin
            if ((state == WAIT0) || (state == WAIT1)) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            if (state == IDLE) begin
                to_flag <= 1'b0;
            end else if (timed_out) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign timeout_err = (state == ACK) && to_flag;
`else
    assign timed_out   = 1'b0;
    // Always false; keeps TIMEOUT_CYC referenced when the watchdog is not built.
    assign timeout_err = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_valid) state_nx = START0;
            START0:  state_nx = WAIT0;
            WAIT0: begin
                if (done_ok)        state_nx = START1;
                else if (timed_out) state_nx = ACK;
            end
            START1:  state_nx = WAIT1;
            WAIT1:   if (done_ok || timed_out) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state == ACK) begin
            ack[win_idx] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            rr_ptr   <= '0;
            win_idx  <= '0;
            resp_q   <= '0;
            dado_q   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win_idx <= pick_idx;
                        resp_q  <= resp_in[BYTE_W*int'(pick_idx) +: BYTE_W];
                        dado_q  <= dado_in[BYTE_W*int'(pick_idx) +: BYTE_W];
                    end
                end
                START0: begin
                    tx_data  <= resp_q;
                    tx_start <= 1'b1;
                end
                START1: begin
                    tx_data  <= dado_q;
                    tx_start <= 1'b1;
                end
                ACK: begin
                    // The requester just served becomes lowest priority next round.
                    rr_ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
